// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed display scan logic.
// Helpers work on the widest supported digit vector; callers narrow the result.
package display_pkg;

  localparam int unsigned BCD_W          = 4;
  localparam int unsigned NUM_DIGITS_DEF = 4;
  localparam int unsigned MAX_DIGITS     = 16;

  typedef logic [BCD_W-1:0] bcd_t;

  function automatic logic [MAX_DIGITS-1:0] onehot(input int unsigned idx);
    return MAX_DIGITS'(1) << idx;
  endfunction

  function automatic bcd_t digit_at(input logic [BCD_W*MAX_DIGITS-1:0] vec,
                                    input int unsigned k);
    return vec[k*BCD_W +: BCD_W];
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running prescaler: o_tick is high for one cycle out of every SCAN_DIV.
module scan_tick_gen #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);

  localparam int unsigned     CntW   = $clog2(SCAN_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);

  logic [CntW-1:0] r_cnt;

  assign o_tick = (r_cnt == CntMax);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Scans committed BCD digits onto a shared registered decoder with one-hot digit select,
// frame-synchronous load commit, leading-zero blanking and whole-display blink.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = NUM_DIGITS_DEF,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_load,
  input  logic [BCD_W*NUM_DIGITS-1:0] i_digits_in,
  input  logic                        i_blank_lz,
  input  logic                        i_blink_en,
  output logic                        o_load_ack,
  output logic [BCD_W-1:0]            o_bcd_out,
  output logic [NUM_DIGITS-1:0]       o_dig_sel
);

  localparam int unsigned     IdxW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IdxW-1:0] IdxMax = IdxW'(NUM_DIGITS - 1);
  localparam int unsigned     BlkW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BlkW-1:0] BlkMax = BlkW'(BLINK_FRAMES - 1);

  logic                          w_tick;
  logic                          w_fb;
  logic                          w_commit;
  logic                          w_dark;
  logic                          w_upper_zero;
  logic [NUM_DIGITS-1:0]         w_lz_blank;
  logic [BCD_W*MAX_DIGITS-1:0]   w_active_ext;

  logic [IdxW-1:0]               r_idx;
  logic [IdxW-1:0]               r_idx_d;
  logic [BCD_W*NUM_DIGITS-1:0]   r_pending;
  logic                          r_pending_v;
  logic [BCD_W*NUM_DIGITS-1:0]   r_active;
  logic                          r_load_ack;
  logic [BCD_W-1:0]              r_bcd;
  logic [NUM_DIGITS-1:0]         r_dig_sel;
  logic                          r_live;
  logic [BlkW-1:0]               r_blink_cnt;
  logic                          r_blink_ph;

  scan_tick_gen #(
    .SCAN_DIV (SCAN_DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .o_tick (w_tick)
  );

  assign w_fb     = w_tick & (r_idx == IdxMax);
  assign w_commit = w_fb & r_pending_v;

  always_comb begin
    w_active_ext = '0;
    w_active_ext[BCD_W*NUM_DIGITS-1:0] = r_active;
  end

  // Walk from the most significant digit down so each digit knows if all above it are zero.
  always_comb begin
    w_upper_zero = 1'b1;
    w_lz_blank   = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_upper_zero  = w_upper_zero & (digit_at(w_active_ext, unsigned'(k)) == '0);
      w_lz_blank[k] = i_blank_lz & w_upper_zero & (k != 0);
    end
  end

  assign w_dark = w_lz_blank[r_idx_d] | (i_blink_en & r_blink_ph);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_idx_d <= '0;
    end else begin
      r_idx_d <= r_idx;
      if (w_tick) begin
        r_idx <= (r_idx == IdxMax) ? '0 : r_idx + 1'b1;
      end
    end
  end

  // A load coincident with the frame boundary refills pending after the old value commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending   <= '0;
      r_pending_v <= 1'b0;
      r_active    <= '0;
      r_load_ack  <= 1'b0;
    end else begin
      if (i_load) begin
        r_pending   <= i_digits_in;
        r_pending_v <= 1'b1;
      end else if (w_commit) begin
        r_pending_v <= 1'b0;
      end
      if (w_commit) begin
        r_active <= r_pending;
      end
      r_load_ack <= w_commit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink_cnt <= '0;
      r_blink_ph  <= 1'b0;
    end else if (!i_blink_en) begin
      r_blink_cnt <= '0;
      r_blink_ph  <= 1'b0;
    end else if (w_fb) begin
      if (r_blink_cnt == BlkMax) begin
        r_blink_cnt <= '0;
        r_blink_ph  <= ~r_blink_ph;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  // r_live holds the display dark for the first edge so dig_sel lines up with decoder output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_live    <= 1'b0;
      r_bcd     <= '0;
      r_dig_sel <= '0;
    end else begin
      r_live    <= 1'b1;
      r_bcd     <= digit_at(w_active_ext, 32'(r_idx));
      r_dig_sel <= r_live ? (NUM_DIGITS'(onehot(32'(r_idx_d))) & {NUM_DIGITS{~w_dark}})
                          : '0;
    end
  end

  assign o_load_ack = r_load_ack;
  assign o_bcd_out  = r_bcd;
  assign o_dig_sel  = r_dig_sel;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with SCAN_DIV=4, NUM_DIGITS=4, BLINK_FRAMES=2.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;
  logic        blank_lz = 1'b0;
  logic        blink_en = 1'b0;
  logic        load_ack;
  logic [3:0]  bcd_out;
  logic [3:0]  dig_sel;

  int errors = 0;
  int checks = 0;
  int n = 0;  // posedges since reset release

  display_scan_ctrl #(
    .NUM_DIGITS   (4),
    .SCAN_DIV     (4),
    .BLINK_FRAMES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_load      (load),
    .i_digits_in (digits_in),
    .i_blank_lz  (blank_lz),
    .i_blink_en  (blink_en),
    .o_load_ack  (load_ack),
    .o_bcd_out   (bcd_out),
    .o_dig_sel   (dig_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s n=%0d: observed=%h expected=%h", tag, n, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  // One full frame starting on a frame boundary; the first sample after the boundary is
  // skipped because bcd_out has already moved to the newly committed value.
  task automatic run_frame(input logic [15:0] show, input bit lz, input bit dark,
                           input int la0, input logic [15:0] lv0,
                           input int la1, input logic [15:0] lv1, input bit ack_end);
    int          kb;
    int          ks;
    logic [15:0] sh;
    logic [3:0]  exp_sel;
    bit          lit;
    blank_lz = lz;
    for (int j = 1; j <= 16; j++) begin
      if (j == la0) begin
        load = 1'b1;
        digits_in = lv0;
      end else if (j == la1) begin
        load = 1'b1;
        digits_in = lv1;
      end
      step();
      load = 1'b0;
      if (n % 16 == 1) begin
        if (n == 1) chk("dig_sel_first_edge", 16'(dig_sel), 16'h0);
        chk("load_ack", 16'(load_ack), 16'h0);
      end else begin
        kb = ((n - 1) / 4) % 4;
        sh = show >> (4 * kb);
        chk("bcd_out", 16'(bcd_out), 16'(sh[3:0]));
        ks = ((n - 2) / 4) % 4;
        sh = show >> (4 * ks);
        lit = !dark && !(lz && ks != 0 && sh == 16'h0);
        exp_sel = lit ? (4'b0001 << ks) : 4'b0000;
        chk("dig_sel", 16'(dig_sel), 16'(exp_sel));
        chk("load_ack", 16'(load_ack), (j == 16) ? 16'(ack_end) : 16'h0);
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dig_sel", 16'(dig_sel), 16'h0);
    chk("rst_bcd_out", 16'(bcd_out), 16'h0);
    chk("rst_load_ack", 16'(load_ack), 16'h0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;

    run_frame(16'h0000, 0, 0, -1, 16'h0, -1, 16'h0, 0);
    run_frame(16'h0000, 0, 0,  5, 16'h1234, -1, 16'h0, 1);
    run_frame(16'h1234, 0, 0, -1, 16'h0, -1, 16'h0, 0);
    run_frame(16'h1234, 1, 0,  3, 16'h0007, -1, 16'h0, 1);
    run_frame(16'h0007, 1, 0,  2, 16'h0000, -1, 16'h0, 1);
    run_frame(16'h0000, 1, 0,  4, 16'h1111,  9, 16'h2222, 1);
    run_frame(16'h2222, 0, 0,  5, 16'h4444, 16, 16'h3333, 1);
    run_frame(16'h4444, 0, 0, -1, 16'h0, -1, 16'h0, 1);
    run_frame(16'h3333, 1, 0,  5, 16'h0A00, -1, 16'h0, 1);

    blink_en = 1'b1;
    run_frame(16'h0A00, 1, 0, -1, 16'h0, -1, 16'h0, 0);
    run_frame(16'h0A00, 1, 0, -1, 16'h0, -1, 16'h0, 0);
    run_frame(16'h0A00, 1, 1, -1, 16'h0, -1, 16'h0, 0);
    run_frame(16'h0A00, 1, 1, -1, 16'h0, -1, 16'h0, 0);
    run_frame(16'h0A00, 1, 0, -1, 16'h0, -1, 16'h0, 0);
    run_frame(16'h0A00, 1, 0, -1, 16'h0, -1, 16'h0, 0);
    run_frame(16'h0A00, 1, 1, -1, 16'h0, -1, 16'h0, 0);
    blink_en = 1'b0;
    run_frame(16'h0A00, 1, 0, -1, 16'h0, -1, 16'h0, 0);

    // Reset in the middle of a frame with a load still pending.
    step();
    step();
    load = 1'b1;
    digits_in = 16'h5678;
    step();
    load = 1'b0;
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_dig_sel", 16'(dig_sel), 16'h0);
    chk("midrst_bcd_out", 16'(bcd_out), 16'h0);
    chk("midrst_load_ack", 16'(load_ack), 16'h0);
    @(posedge clk);
    #1;
    chk("midrst_hold_dig_sel", 16'(dig_sel), 16'h0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    run_frame(16'h0000, 0, 0, -1, 16'h0, -1, 16'h0, 0);
    run_frame(16'h0000, 0, 0, -1, 16'h0, -1, 16'h0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
